// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation pipeline.
//   imm_src_e  : ImmSrc mode encodings (RSVD6/RSVD7 are the undefined modes)
//   s1_data_t  : payload held by stage 1 (raw field, mode, carry, rotate amount)
//   ROT_W      : width of the ARM rotated-immediate datapath
//   xlen_legal : elaboration-time check on the datapath width
package imm_pkg;

   localparam int ROT_W = 32;

   typedef enum logic [2:0] {
      IMM8   = 3'b000,
      IMM12  = 3'b001,
      BRANCH = 3'b010,
      ROT    = 3'b011,
      MOVW   = 3'b100,
      OFF24  = 3'b101,
      RSVD6  = 3'b110,
      RSVD7  = 3'b111
   } imm_src_e;

   typedef struct packed {
      logic [23:0] raw;
      imm_src_e    mode;
      logic        carry;
      logic [3:0]  rot;
   } s1_data_t;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_rotator.sv
// ARM rotated-immediate decoder: ROR32(ZE32(imm8), 2*rot4) plus shifter carry.
//   imm8_i  : 8-bit immediate field
//   rot4_i  : 4-bit rotate field (rotation amount is twice this value)
//   carry_i : current C flag, forwarded when no rotation takes place
//   value_o : rotated 32-bit value
//   carry_o : bit 31 of the result when rotated, otherwise carry_i
module imm_rotator
   import imm_pkg::*;
(
   input  logic [7:0]       imm8_i,
   input  logic [3:0]       rot4_i,
   input  logic             carry_i,
   output logic [ROT_W-1:0] value_o,
   output logic             carry_o
);

   logic [4:0]       amt;
   logic [ROT_W-1:0] base;

   assign amt  = {rot4_i, 1'b0};
   assign base = {24'h000000, imm8_i};

   // A left shift by 32 yields zero, so amt == 0 degenerates cleanly to base.
   assign value_o = (base >> amt) | (base << (6'd32 - {1'b0, amt}));
   assign carry_o = (rot4_i != 4'd0) ? value_o[ROT_W-1] : carry_i;

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate generator for the decode stage.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (Instr, ImmSrc, CarryIn)
//   flush               : drops everything in flight on the next edge
//   out_valid/out_ready : result handshake (ExtImm, ShCarry, ImmIllegal)
// S1 selects and registers the raw field; S2 rotates/extends and registers
// the result. Each stage is ready when empty or when its consumer is ready.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int SRC_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [23:0]      Instr,
   input  logic [SRC_W-1:0] ImmSrc,
   input  logic             CarryIn,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ExtImm,
   output logic             ShCarry,
   output logic             ImmIllegal
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_extend_pipe: XLEN must be 32 or 64");
   end
   if (SRC_W < 3) begin : g_bad_src_w
      $error("imm_extend_pipe: SRC_W must be at least 3");
   end

   // ---------------- handshake / valid chain ----------------
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_ready, s2_ready;
   logic s1_load, s2_load;

   assign s2_ready = !s2_valid_q || out_ready;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign in_ready = s1_ready;
   assign s1_load  = in_valid && s1_ready && !flush;
   assign s2_load  = s1_valid_q && s2_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s1_load)      s1_valid_d = 1'b1;
         else if (s2_load) s1_valid_d = 1'b0;
         if (s2_load)        s2_valid_d = 1'b1;
         else if (out_ready) s2_valid_d = 1'b0;
      end
   end

   // ---------------- stage 1: field select ----------------
   s1_data_t s1_d, s1_q;
   imm_src_e mode_d;

   always_comb begin
      // Any encoding beyond the 3-bit mode space is folded into an undefined mode.
      if ((ImmSrc >> 3) != '0) mode_d = RSVD7;
      else                     mode_d = imm_src_e'(ImmSrc[2:0]);

      s1_d.mode  = mode_d;
      s1_d.carry = CarryIn;
      s1_d.rot   = (mode_d == ROT) ? Instr[11:8] : 4'd0;
      case (mode_d)
         IMM8, ROT:     s1_d.raw = {16'h0000, Instr[7:0]};
         IMM12:         s1_d.raw = {12'h000, Instr[11:0]};
         MOVW:          s1_d.raw = {8'h00, Instr[19:16], Instr[11:0]};
         BRANCH, OFF24: s1_d.raw = Instr;
         default:       s1_d.raw = 24'h000000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         // NOTE: data registers are reset too, so outputs read 0 rather than X after reset.
         s1_q.raw   <= 24'h000000;
         s1_q.mode  <= IMM8;
         s1_q.carry <= 1'b0;
         s1_q.rot   <= 4'd0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_load) s1_q <= s1_d;
      end
   end

   // ---------------- stage 2: rotate / extend ----------------
   logic [ROT_W-1:0] rot_val;
   logic             rot_carry;
   logic [XLEN-1:0]  ext_d, ext_q;
   logic             carry_d, carry_q;
   logic             ill_d, ill_q;

   imm_rotator u_rot (
      .imm8_i  (s1_q.raw[7:0]),
      .rot4_i  (s1_q.rot),
      .carry_i (s1_q.carry),
      .value_o (rot_val),
      .carry_o (rot_carry)
   );

   always_comb begin
      ext_d   = '0;
      carry_d = s1_q.carry;
      ill_d   = 1'b0;
      case (s1_q.mode)
         IMM8, IMM12, MOVW: ext_d = XLEN'(s1_q.raw);
         BRANCH:            ext_d = XLEN'($signed({s1_q.raw, 2'b00}));
         OFF24:             ext_d = XLEN'($signed(s1_q.raw));
         ROT: begin
            ext_d   = XLEN'(rot_val);
            carry_d = rot_carry;
         end
         default:           ill_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_q   <= '0;
         carry_q <= 1'b0;
         ill_q   <= 1'b0;
      end else if (s2_load) begin
         ext_q   <= ext_d;
         carry_q <= carry_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign ExtImm     = ext_q;
   assign ShCarry    = carry_q;
   assign ImmIllegal = ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a 32-bit and a 64-bit instance
// share the same stimulus; results are compared against a table of constants
// and against a behavioural model (queue of in-flight requests).
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] Instr = '0;
   logic [2:0]  ImmSrc = '0;
   logic        CarryIn = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, ShCarry, ImmIllegal;
   logic [31:0] ExtImm;
   logic        in_ready64, out_valid64, ShCarry64, ImmIllegal64;
   logic [63:0] ExtImm64;

   always #5 clk = ~clk;

   imm_extend_pipe #(.XLEN(32), .SRC_W(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Instr(Instr), .ImmSrc(ImmSrc), .CarryIn(CarryIn), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .ExtImm(ExtImm),
      .ShCarry(ShCarry), .ImmIllegal(ImmIllegal)
   );

   imm_extend_pipe #(.XLEN(64), .SRC_W(3)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
      .Instr(Instr), .ImmSrc(ImmSrc), .CarryIn(CarryIn), .flush(flush),
      .out_valid(out_valid64), .out_ready(out_ready), .ExtImm(ExtImm64),
      .ShCarry(ShCarry64), .ImmIllegal(ImmIllegal64)
   );

   typedef struct {
      logic [63:0] e64;
      logic        c;
      logic        ill;
      int          acc;
   } exp_t;

   typedef struct {
      logic [2:0]  src;
      logic [23:0] instr;
      logic        cin;
      logic [63:0] exp64;
      logic        c;
      logic        ill;
   } vec_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_acc = 0;
   int   n_out = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: immediate value computed straight from the mode definitions.
   function automatic void ref_imm(input logic [2:0] src, input logic [23:0] ins, input logic cin,
                                   output logic [63:0] v, output logic c, output logic ill);
      longint      s;
      logic [31:0] r;
      s   = ins[23] ? longint'(ins) - 64'sd16777216 : longint'(ins);
      v   = '0;
      c   = cin;
      ill = 1'b0;
      case (src)
         3'd0: v = 64'(ins[7:0]);
         3'd1: v = 64'(ins[11:0]);
         3'd2: v = s * 4;
         3'd3: begin
            r = 32'(ins[7:0]);
            for (int k = 0; k < 2 * int'(ins[11:8]); k++) r = {r[0], r[31:1]};
            v = 64'(r);
            if (ins[11:8] != 4'd0) c = r[31];
         end
         3'd4: v = 64'(ins[19:16]) * 4096 + 64'(ins[11:0]);
         3'd5: v = s;
         default: ill = 1'b1;
      endcase
   endfunction

   // One clock: check outputs against the model at the falling edge, then
   // advance the model at the rising edge. Returns 1 time unit after the edge.
   task automatic cycle();
      exp_t        e;
      logic [63:0] v;
      logic        c, ill;
      bit          exp_ov, exp_ir, acc, cons;
      @(negedge clk);
      exp_ov = (q.size() > 0) && (q[0].acc < cyc);
      exp_ir = (q.size() < 2) || out_ready;
      check("out_valid", out_valid, exp_ov);
      check("out_valid64", out_valid64, exp_ov);
      check("in_ready", in_ready, exp_ir);
      check("in_ready64", in_ready64, exp_ir);
      if (exp_ov) begin
         check("ExtImm", ExtImm, q[0].e64[31:0]);
         check("ExtImm64", ExtImm64, q[0].e64);
         check("ShCarry", ShCarry, q[0].c);
         check("ImmIllegal", ImmIllegal, q[0].ill);
         check("ImmIllegal64", ImmIllegal64, q[0].ill);
      end
      acc  = reset && in_valid && exp_ir && !flush;
      cons = reset && exp_ov && out_ready;
      ref_imm(ImmSrc, Instr, CarryIn, v, c, ill);
      @(posedge clk);
      cyc++;
      if (!reset) begin
         q.delete();
      end else begin
         if (cons) begin
            void'(q.pop_front());
            n_out++;
         end
         if (flush) begin
            q.delete();
         end else if (acc) begin
            e.e64 = v; e.c = c; e.ill = ill; e.acc = cyc;
            q.push_back(e);
            n_acc++;
         end
      end
      #1;
   endtask

   task automatic drive(input logic [2:0] src, input logic [23:0] ins, input logic cin);
      ImmSrc  = src;
      Instr   = ins;
      CarryIn = cin;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[];
      int   base;

      vecs = '{
         '{3'd0, 24'h0000A5, 1'b0, 64'h00000000000000A5, 1'b0, 1'b0},
         '{3'd2, 24'hFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0},
         '{3'd3, 24'h0004FF, 1'b0, 64'h00000000FF000000, 1'b1, 1'b0},
         '{3'd3, 24'h0000FF, 1'b1, 64'h00000000000000FF, 1'b1, 1'b0},
         '{3'd4, 24'h05ABCD, 1'b1, 64'h0000000000005BCD, 1'b1, 1'b0},
         '{3'd7, 24'h123456, 1'b0, 64'h0000000000000000, 1'b0, 1'b1},
         '{3'd6, 24'hFFFFFF, 1'b1, 64'h0000000000000000, 1'b1, 1'b1},
         '{3'd2, 24'h800000, 1'b0, 64'hFFFFFFFFFE000000, 1'b0, 1'b0},
         '{3'd5, 24'h800001, 1'b1, 64'hFFFFFFFFFF800001, 1'b1, 1'b0},
         '{3'd1, 24'hFFFABC, 1'b0, 64'h0000000000000ABC, 1'b0, 1'b0},
         '{3'd3, 24'h000F01, 1'b1, 64'h0000000000000004, 1'b0, 1'b0},
         '{3'd3, 24'h000102, 1'b0, 64'h0000000080000000, 1'b1, 1'b0},
         '{3'd5, 24'h7FFFFF, 1'b0, 64'h00000000007FFFFF, 1'b0, 1'b0}
      };

      // Reset values while reset is held low.
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_ExtImm", ExtImm, 0);
      check("rst_ExtImm64", ExtImm64, 0);
      check("rst_ShCarry", ShCarry, 0);
      check("rst_ImmIllegal", ImmIllegal, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 reset = 1'b1;

      // Directed table: one request at a time, result checked two edges later.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].src, vecs[i].instr, vecs[i].cin);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         cycle();
         in_valid = 1'b0;
         cycle();
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_ExtImm", i), ExtImm, vecs[i].exp64[31:0]);
         check($sformatf("vec%0d_ExtImm64", i), ExtImm64, vecs[i].exp64);
         check($sformatf("vec%0d_ShCarry", i), ShCarry, vecs[i].c);
         check($sformatf("vec%0d_ShCarry64", i), ShCarry64, vecs[i].c);
         check($sformatf("vec%0d_ImmIllegal", i), ImmIllegal, vecs[i].ill);
      end
      cycle();

      // Streaming: 8 back-to-back requests, one result per cycle.
      base = n_out;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(3'($urandom_range(0, 5)), 24'($urandom), 1'($urandom));
         in_valid = 1'b1;
         cycle();
      end
      in_valid = 1'b0;
      repeat (3) cycle();
      check("stream_count", n_out - base, 8);

      // Backpressure: out_ready low for 5 cycles with a continuous input stream.
      base = n_acc;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(3'd1, 24'h000100 + 24'(i), 1'b0);
         cycle();
         if (i >= 1) check("bp_hold_ExtImm", ExtImm, 32'h00000100);
      end
      check("bp_accepted", n_acc - base, 2);
      check("bp_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      base = n_out;
      repeat (4) cycle();
      check("bp_drain", n_out - base, 2);

      // Flush with both stages full, together with out_ready and in_valid.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'd0, 24'h000011, 1'b0);
      cycle();
      drive(3'd0, 24'h000022, 1'b0);
      cycle();
      flush     = 1'b1;
      out_ready = 1'b1;
      drive(3'd0, 24'h000033, 1'b0);
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("flush_empty", out_valid, 0);
      end

      // Asynchronous reset between edges with a result sitting in S2.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'd3, 24'h0004FF, 1'b0);
      cycle();
      drive(3'd0, 24'h0000A5, 1'b0);
      cycle();
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_ExtImm", ExtImm, 0);
      check("arst_ExtImm64", ExtImm64, 0);
      check("arst_ShCarry", ShCarry, 0);
      check("arst_ImmIllegal", ImmIllegal, 0);
      check("arst_in_ready", in_ready, 1);
      q.delete();
      cycle();
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (2) cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 31) == 0);
         drive(3'($urandom_range(0, 7)), 24'($urandom), 1'($urandom));
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();
      check("final_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
